matched_filter_mac: RTL

Time-multiplexed FIR (matched) filter sitting directly downstream of setupCoefficients. It captures a serial stream of LENGTH signed coefficients after reset. It then accepts input samples one at a time and, for each sample, computes the full LENGTH-tap convolution with a single multiply-accumulate unit. Each result is emitted as a one-cycle valid pulse.

---
 rtl/matched_filter_mac.sv | 110 +++++++++++
 1 files changed

// File: rtl/matched_filter_mac.sv
// matched_filter_mac: serial-coefficient FIR filter computing each output with one time-multiplexed MAC
module matched_filter_mac #(
  parameter int LENGTH = 20,
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH = 21
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] coefficientIn,
  input  logic                  coefficientValid,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  dataInValid,
  output logic                  dataInReady,
  output logic                  coefficientsLoaded,
  output logic [OUT_WIDTH-1:0]  dataOut,
  output logic                  dataOutValid
);
  localparam logic [1:0] LOAD = 2'd0, WAIT = 2'd1, MAC = 2'd2;
  localparam int IW = $clog2(LENGTH);
  localparam logic [IW-1:0] LAST = IW'(LENGTH - 1);
  logic [1:0] state_q, state_d;
  logic signed [DATA_WIDTH-1:0] coeff_q [LENGTH];
  logic signed [DATA_WIDTH-1:0] coeff_d [LENGTH];
  logic signed [DATA_WIDTH-1:0] x_q [LENGTH];
  logic signed [DATA_WIDTH-1:0] x_d [LENGTH];
  logic signed [OUT_WIDTH-1:0] acc_q, acc_d, out_q, out_d, sum;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic [IW-1:0] k_q, k_d, i_q, i_d;
  logic valid_q, valid_d, loaded_q, loaded_d;
  assign prod = coeff_q[i_q] * x_q[i_q];
  assign sum = acc_q + OUT_WIDTH'(prod);
  assign dataInReady = state_q == WAIT;
  assign coefficientsLoaded = loaded_q;
  assign dataOut = out_q;
  assign dataOutValid = valid_q;
  always_comb begin
    state_d = state_q;
    coeff_d = coeff_q;
    x_d = x_q;
    acc_d = acc_q;
    out_d = out_q;
    k_d = k_q;
    i_d = i_q;
    valid_d = 1'b0;
    loaded_d = loaded_q;
    if (state_q == LOAD) begin
      if (coefficientValid) begin
        coeff_d[k_q] = coefficientIn;
        k_d = k_q + 1'b1;
        if (k_q == LAST) begin
          state_d = WAIT;
          loaded_d = 1'b1;
        end
      end
    end else if (state_q == WAIT) begin
      if (dataInValid) begin
        for (int j = 1; j < LENGTH; j++) x_d[j] = x_q[j-1];
        x_d[0] = dataIn;
        acc_d = '0;
        i_d = '0;
        state_d = MAC;
      end
    end else if (state_q == MAC) begin
      acc_d = sum;
      i_d = i_q + 1'b1;
      if (i_q == LAST) begin
        out_d = sum;
        valid_d = 1'b1;
        state_d = WAIT;
      end
    end else begin
      // illegal encoding: wipe everything so a fresh load is required
      for (int j = 0; j < LENGTH; j++) begin
        coeff_d[j] = '0;
        x_d[j] = '0;
      end
      acc_d = '0;
      out_d = '0;
      k_d = '0;
      i_d = '0;
      loaded_d = 1'b0;
      state_d = LOAD;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      for (int j = 0; j < LENGTH; j++) begin
        coeff_q[j] <= '0;
        x_q[j] <= '0;
      end
      acc_q <= '0;
      out_q <= '0;
      k_q <= '0;
      i_q <= '0;
      valid_q <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      state_q <= state_d;
      coeff_q <= coeff_d;
      x_q <= x_d;
      acc_q <= acc_d;
      out_q <= out_d;
      k_q <= k_d;
      i_q <= i_d;
      valid_q <= valid_d;
      loaded_q <= loaded_d;
    end
  end
endmodule
